logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

Parametrised, registered successor to the two-input gate: applies one of eight selectable bitwise operations across NIN operands of WIDTH bits per beat. It either returns one result per beat or folds a multi-beat burst into a single result. Operand beats and results move over valid/ready handshakes. It sits between lab stimulus sources (switch/UART front ends) and display or result sinks.

## Interface
- WIDTH, 8: bits per operand and result.
- NIN, 2: operands per beat, 2..8.
- CNTW, 8: width of the beat counter.
- Clk  in  1: sole clock, rising edge.
- Reset  in  1: synchronous, active-high.
- InValid  in  1: operand beat present.
- InReady  out  1: block accepts the beat this cycle.
- A  in  NIN*WIDTH: operands; operand k is A[k*WIDTH +: WIDTH].
- Op  in  3: operation code.
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - 6 PASS returns operand 0.
  - 7 NOT returns ~operand 0.
- Acc  in  1: beat starts an accumulate burst.
- Last  in  1: final beat of a burst.
- OutValid  out  1: result present.
- OutReady  in  1: sink takes the result.
- F  out  WIDTH: result.
- Beats  out  CNTW: number of beats folded into F.

## Operation
- A beat is accepted when InValid && InReady.
- InReady = !Reset && (!OutValid || OutReady).
- FSM has two states, IDLE and ACCUM.
- IDLE, accepted beat with Acc=0:
  - F <= op(beat), Beats <= 1, OutValid <= 1.
  - Last is ignored.
- IDLE, accepted beat with Acc=1, Last=1: same as Acc=0 (single-beat burst).
- IDLE, accepted beat with Acc=1, Last=0:
  - Latch Op as burst op.
  - acc <= base(beat), cnt <= 1.
  - Go to ACCUM.
- ACCUM, accepted beat:
  - acc <= base(acc, beat), cnt <= cnt+1 (saturates at 2^CNTW-1).
  - Op and Acc inputs are ignored.
- ACCUM, accepted beat with Last=1:
  - F <= final(acc folded with beat), Beats <= cnt+1, OutValid <= 1.
  - Go to IDLE.
- Base op mapping: AND for AND/NAND, OR for OR/NOR, XOR for XOR/XNOR.
- Inversion for NAND/NOR/XNOR is applied once, at final output only. NAND burst = ~(AND of every operand of every beat).
- PASS/NOT in a burst: operand 0 of the last beat, inverted for NOT.
- Non-last ACCUM beats produce no output.
- Output hold: F, Beats and OutValid are stable while OutValid && !OutReady.
- OutValid clears on OutValid && OutReady unless a new result loads the same cycle.

## Timing
- Reset asserted, observed at next edge:
  - OutValid=0, F=0, Beats=0.
  - State IDLE, acc=0, cnt=0.
- InReady=0 while Reset is high.
- Reset mid-burst discards the accumulator. No partial result is ever emitted.
- Latency: result is visible one cycle after the accepting edge of a single beat or last beat.
- Throughput: one beat per cycle. A result drain and a new load on the same edge give back-to-back OutValid.
- Backpressure: with OutValid=1 and OutReady=0, InReady=0. No beat is accepted, including non-last burst beats.
- InValid with InReady=0: no state change. The source must hold the beat.
- WIDTH arithmetic: purely bitwise, no carries. Beats is the only counter.

## Structure
- Package logic_unit_pkg holds:
  - Op code constants OP_AND..OP_NOT.
  - FSM state encoding S_IDLE, S_ACCUM.
  - Base-op encoding.
- Sub-module logic_reduce: combinational. Inputs are the NIN operands, an optional accumulator operand with its enable, and the base op. Output is the WIDTH-bit reduction.
- The top holds the FSM, accumulator, counter, output register and handshake.

## Test plan
- Reset: hold Reset 2 cycles mid-traffic → OutValid=0, F=8'h00, Beats=0, InReady=0 during Reset, InReady=1 after.
- Single beat: WIDTH=8, NIN=2, A={8'hF0,8'h3C}, Op=0, Acc=0 → next cycle OutValid=1, F=8'h30, Beats=1.
- XOR burst: beats {01,02}, {04,08}, {10,20} with Op=2, Acc=1, Last on beat 3 → exactly one result one cycle after beat 3, F=8'h3F, Beats=3.
- NAND burst with Op change mid-burst:
  - Beat 1: {FF,FF}, Op=3.
  - Beat 2: {FF,7F}, Op=1, Last.
  - Expect F=8'h80, Beats=2.
- Backpressure:
  - Result valid and OutReady=0 for 3 cycles → F held, InReady=0, a presented beat is not consumed.
  - OutReady=1 → the beat is accepted that cycle and its result appears next cycle.
- Reset mid-burst: 2 non-last OR beats, then Reset, then a single OR beat {01,00} → F=8'h01, Beats=1, no stale bits.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared opcode, FSM-state and base-op encodings for the logic unit pipeline.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    localparam logic [1:0] BASE_AND  = 2'd0;
    localparam logic [1:0] BASE_OR   = 2'd1;
    localparam logic [1:0] BASE_XOR  = 2'd2;
    localparam logic [1:0] BASE_PASS = 2'd3;

    // Reduction operator underlying each opcode; inversion is handled separately.
    function automatic logic [1:0] base_of(input logic [2:0] op);
        case (op)
            OP_AND, OP_NAND: base_of = BASE_AND;
            OP_OR,  OP_NOR:  base_of = BASE_OR;
            OP_XOR, OP_XNOR: base_of = BASE_XOR;
            default:         base_of = BASE_PASS;
        endcase
    endfunction

    function automatic logic inv_of(input logic [2:0] op);
        inv_of = (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/logic_reduce.sv
// Combinational bitwise reduction of NIN operands, optionally folded with an accumulator.
module logic_reduce
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NIN   = 2
) (
    input  logic [NIN*WIDTH-1:0] operands_i,
    input  logic [WIDTH-1:0]     acc_i,
    input  logic                 acc_en_i,
    input  logic [1:0]           base_i,
    output logic [WIDTH-1:0]     red_o
);

    function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0]       base);
        case (base)
            BASE_AND: fold = a & b;
            BASE_OR:  fold = a | b;
            BASE_XOR: fold = a ^ b;
            default:  fold = a;
        endcase
    endfunction

    logic [WIDTH-1:0] r;

    // PASS keeps operand 0 untouched, so the accumulator never leaks into it.
    always_comb begin
        r = operands_i[WIDTH-1:0];
        for (int unsigned k = 1; k < NIN; k++) begin
            r = fold(r, operands_i[k*WIDTH +: WIDTH], base_i);
        end
        if (acc_en_i) begin
            r = fold(r, acc_i, base_i);
        end
        red_o = r;
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered multi-operand logic unit: per-beat results or burst folding over valid/ready.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NIN   = 2,
    parameter int unsigned CNTW  = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [NIN*WIDTH-1:0] A,
    input  logic [2:0]           Op,
    input  logic                 Acc,
    input  logic                 Last,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [WIDTH-1:0]     F,
    output logic [CNTW-1:0]      Beats
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [0:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic [CNTW-1:0]  beats_q, beats_d;

    logic             accept;
    logic [2:0]       cur_op;
    logic [WIDTH-1:0] red;
    logic [WIDTH-1:0] result;
    logic [CNTW-1:0]  cnt_inc;

    assign InReady = !Reset && (!out_valid_q || OutReady);
    assign accept  = InValid && InReady;
    assign cur_op  = (state_q == S_ACCUM) ? op_q : Op;
    assign result  = inv_of(cur_op) ? ~red : red;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNTW'(1);

    logic_reduce #(
        .WIDTH(WIDTH),
        .NIN  (NIN)
    ) u_reduce (
        .operands_i(A),
        .acc_i     (acc_q),
        .acc_en_i  (state_q == S_ACCUM),
        .base_i    (base_of(cur_op)),
        .red_o     (red)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_AND;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            beats_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            beats_q     <= beats_d;
        end
    end

    // Next state; a result load overrides the drain so results can go back-to-back.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        f_d         = f_q;
        beats_d     = beats_q;

        if (out_valid_q && OutReady) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (Acc && !Last) begin
                        state_d = S_ACCUM;
                        op_d    = Op;
                        acc_d   = red;
                        cnt_d   = CNTW'(1);
                    end else begin
                        out_valid_d = 1'b1;
                        f_d         = result;
                        beats_d     = CNTW'(1);
                    end
                end
                S_ACCUM: begin
                    if (Last) begin
                        out_valid_d = 1'b1;
                        f_d         = result;
                        beats_d     = cnt_inc;
                        state_d     = S_IDLE;
                        acc_d       = '0;
                        cnt_d       = '0;
                    end else begin
                        acc_d = red;
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign OutValid = out_valid_q;
    assign F        = f_q;
    assign Beats    = beats_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: single-beat table, bursts, backpressure and reset.
module tb_logic_unit_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NIN   = 2;
    localparam int unsigned CNTW  = 8;

    logic                 Clk;
    logic                 Reset;
    logic                 InValid;
    logic                 InReady;
    logic [NIN*WIDTH-1:0] A;
    logic [2:0]           Op;
    logic                 Acc;
    logic                 Last;
    logic                 OutValid;
    logic                 OutReady;
    logic [WIDTH-1:0]     F;
    logic [CNTW-1:0]      Beats;

    int n_checks = 0;
    int n_errors = 0;

    logic_unit_pipe #(
        .WIDTH(WIDTH),
        .NIN  (NIN),
        .CNTW (CNTW)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .InValid (InValid),
        .InReady (InReady),
        .A       (A),
        .Op      (Op),
        .Acc     (Acc),
        .Last    (Last),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .F       (F),
        .Beats   (Beats)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [2:0]  op;
        logic [7:0]  f;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one beat, let one edge pass, sample 1 time unit after it.
    task automatic drive(input logic [15:0] a, input logic [2:0] op,
                         input logic acc, input logic last);
        InValid = 1'b1;
        A       = a;
        Op      = op;
        Acc     = acc;
        Last    = last;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        Acc     = 1'b0;
        Last    = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"and_f03c",  16'hF03C, 3'd0, 8'h30};
        vecs[1]  = '{"or_f03c",   16'hF03C, 3'd1, 8'hFC};
        vecs[2]  = '{"xor_f03c",  16'hF03C, 3'd2, 8'hCC};
        vecs[3]  = '{"nand_f03c", 16'hF03C, 3'd3, 8'hCF};
        vecs[4]  = '{"nor_f03c",  16'hF03C, 3'd4, 8'h03};
        vecs[5]  = '{"xnor_f03c", 16'hF03C, 3'd5, 8'h33};
        vecs[6]  = '{"pass_f03c", 16'hF03C, 3'd6, 8'h3C};
        vecs[7]  = '{"not_f03c",  16'hF03C, 3'd7, 8'hC3};
        vecs[8]  = '{"and_aa0f",  16'hAA0F, 3'd0, 8'h0A};
        vecs[9]  = '{"or_aa0f",   16'hAA0F, 3'd1, 8'hAF};
        vecs[10] = '{"xor_aa0f",  16'hAA0F, 3'd2, 8'hA5};
        vecs[11] = '{"nor_00ff",  16'h00FF, 3'd4, 8'h00};
        vecs[12] = '{"pass_00ff", 16'h00FF, 3'd6, 8'hFF};
        vecs[13] = '{"not_00ff",  16'h00FF, 3'd7, 8'h00};

        Reset    = 1'b1;
        InValid  = 1'b0;
        A        = '0;
        Op       = 3'd0;
        Acc      = 1'b0;
        Last     = 1'b0;
        OutReady = 1'b1;

        idle_cycle();
        check("rst_inready_low", 32'(InReady), 32'd0);
        idle_cycle();
        check("rst_outvalid", 32'(OutValid), 32'd0);
        check("rst_f", 32'(F), 32'd0);
        check("rst_beats", 32'(Beats), 32'd0);
        Reset = 1'b0;
        #1;
        check("rst_inready_after", 32'(InReady), 32'd1);

        // Back-to-back single beats, Acc=0 with Last set to show it is ignored.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].a, vecs[i].op, 1'b0, 1'b1);
            check({vecs[i].name, "_valid"}, 32'(OutValid), 32'd1);
            check({vecs[i].name, "_f"}, 32'(F), 32'(vecs[i].f));
            check({vecs[i].name, "_beats"}, 32'(Beats), 32'd1);
        end
        idle_cycle();
        check("drain_valid", 32'(OutValid), 32'd0);

        // Acc=1 with Last=1 in IDLE is a single-beat burst.
        drive(16'hF03C, 3'd3, 1'b1, 1'b1);
        check("acc_last_f", 32'(F), 32'hCF);
        check("acc_last_beats", 32'(Beats), 32'd1);
        idle_cycle();

        // XOR burst over three beats.
        drive(16'h0201, 3'd2, 1'b1, 1'b0);
        check("xor_b1_novalid", 32'(OutValid), 32'd0);
        drive(16'h0804, 3'd2, 1'b1, 1'b0);
        check("xor_b2_novalid", 32'(OutValid), 32'd0);
        drive(16'h2010, 3'd2, 1'b1, 1'b1);
        check("xor_burst_valid", 32'(OutValid), 32'd1);
        check("xor_burst_f", 32'(F), 32'h3F);
        check("xor_burst_beats", 32'(Beats), 32'd3);
        idle_cycle();
        check("xor_burst_once", 32'(OutValid), 32'd0);

        // NAND burst; the Op change on the last beat must be ignored.
        drive(16'hFFFF, 3'd3, 1'b1, 1'b0);
        drive(16'hFF7F, 3'd1, 1'b0, 1'b1);
        check("nand_burst_f", 32'(F), 32'h80);
        check("nand_burst_beats", 32'(Beats), 32'd2);
        idle_cycle();

        // NOT burst returns ~operand 0 of the last beat.
        drive(16'h2211, 3'd7, 1'b1, 1'b0);
        drive(16'h445A, 3'd0, 1'b1, 1'b1);
        check("not_burst_f", 32'(F), 32'hA5);
        check("not_burst_beats", 32'(Beats), 32'd2);
        idle_cycle();

        // Beat counter saturation over a 300-beat OR burst.
        drive(16'h0000, 3'd1, 1'b1, 1'b0);
        for (int i = 0; i < 298; i++) begin
            drive(16'h0000, 3'd1, 1'b1, 1'b0);
        end
        check("sat_novalid", 32'(OutValid), 32'd0);
        drive(16'h0080, 3'd1, 1'b1, 1'b1);
        check("sat_f", 32'(F), 32'h80);
        check("sat_beats", 32'(Beats), 32'hFF);
        idle_cycle();

        // Backpressure: held result, blocked beat, release.
        OutReady = 1'b0;
        drive(16'hF03C, 3'd0, 1'b0, 1'b0);
        check("bp_valid", 32'(OutValid), 32'd1);
        check("bp_f", 32'(F), 32'h30);
        InValid = 1'b1;
        A       = 16'hAA0F;
        Op      = 3'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_inready_low", 32'(InReady), 32'd0);
            @(posedge Clk);
            #1;
            check("bp_hold_valid", 32'(OutValid), 32'd1);
            check("bp_hold_f", 32'(F), 32'h30);
            check("bp_hold_beats", 32'(Beats), 32'd1);
        end
        OutReady = 1'b1;
        #1;
        check("bp_release_inready", 32'(InReady), 32'd1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        check("bp_release_valid", 32'(OutValid), 32'd1);
        check("bp_release_f", 32'(F), 32'hAF);
        idle_cycle();
        check("bp_release_drain", 32'(OutValid), 32'd0);

        // Reset mid-traffic with a held result.
        OutReady = 1'b0;
        drive(16'hF03C, 3'd0, 1'b0, 1'b0);
        Reset = 1'b1;
        #1;
        check("rst2_inready_low", 32'(InReady), 32'd0);
        idle_cycle();
        idle_cycle();
        check("rst2_outvalid", 32'(OutValid), 32'd0);
        check("rst2_f", 32'(F), 32'd0);
        check("rst2_beats", 32'(Beats), 32'd0);
        check("rst2_inready_hold", 32'(InReady), 32'd0);
        Reset    = 1'b0;
        OutReady = 1'b1;
        #1;
        check("rst2_inready_after", 32'(InReady), 32'd1);

        // Reset mid-burst discards the accumulator.
        drive(16'hFFFF, 3'd1, 1'b1, 1'b0);
        drive(16'hFFFF, 3'd1, 1'b1, 1'b0);
        Reset = 1'b1;
        idle_cycle();
        check("rst3_novalid", 32'(OutValid), 32'd0);
        Reset = 1'b0;
        drive(16'h0100, 3'd1, 1'b0, 1'b0);
        check("rst3_valid", 32'(OutValid), 32'd1);
        check("rst3_f", 32'(F), 32'h01);
        check("rst3_beats", 32'(Beats), 32'd1);
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
